ii_read_arbiter: RTL and testbench
==================================

Name: ii_read_arbiter

Overview:
Shares the single read port of integral_image_buffer (15-bit address, 20-bit data) between three requesters: the VGA display path (D), the Haar feature evaluator (A) and the window variance unit (B). D has absolute priority, so display timing is never disturbed. A and B share the remaining cycles round-robin. Either may lock the port for multi-read corner bursts. Returned data is tagged back to the originating requester with fixed latency, and sustained starvation of A/B is flagged.

Parameters:
ADDR_W, 15, read address width (integral_image_buffer depth)
DATA_W, 20, integral image word width
RD_LAT, 1, BRAM read latency in cycles from registered address to doutb valid
STARVE_LIMIT, 1023, consecutive denied cycles before starve asserts

Ports:
clk  in  1  single clock, also clkb of the buffer
rst_n  in  1  asynchronous, active-low reset
d_req  in  1  display read request
d_addr  in  ADDR_W  display read address
a_req  in  1  evaluator read request
a_addr  in  ADDR_W  evaluator read address
a_lock  in  1  evaluator holds port after its grant
a_gnt  out  1  evaluator address accepted this cycle (combinational)
b_req  in  1  variance unit read request
b_addr  in  ADDR_W  variance read address
b_lock  in  1  variance unit holds port after its grant
b_gnt  out  1  variance address accepted this cycle (combinational)
bram_addr  out  ADDR_W  registered address to buffer addrb
bram_en  out  1  registered read enable
bram_dout  in  DATA_W  buffer doutb
rd_data  out  DATA_W  registered returned data, shared by all requesters
d_valid, a_valid, b_valid  out  1 each  one-hot strobe qualifying rd_data
starve  out  1  A or B denied for at least STARVE_LIMIT consecutive cycles

Behaviour:
- Accept rule: a request is accepted in cycle N when it is selected. D is accepted whenever d_req=1 and has no gnt output. Requesters hold req and addr until gnt.
- Selection priority per cycle: D > lock owner > round-robin pointer. At most one acceptance per cycle.
- Round-robin: when A and B both request with no lock active, grant the one not granted most recently. Pointer updates only on an A/B grant. After reset it favours A.
- Lock: granted with x_lock=1 makes x the owner. The owner wins over the other requester on subsequent cycles while x_req=1. Ownership clears when the owner is granted with lock=0, or when owner req drops. D still preempts the owner, and the lock persists across the preemption.
- Pipeline: the selected address is registered into bram_addr and bram_en=1 at edge N+1, with a tag (D/A/B) entering a tag shift register of length RD_LAT+1. rd_data is captured from bram_dout and the matching valid pulses for 1 cycle at cycle N+2+RD_LAT, which is 3 cycles with the default parameters. Back-to-back acceptances produce back-to-back valids in order.
- No acceptance: bram_en=0, bram_addr holds its previous value, and the tag is empty. All valids are 0.
- Starvation counter: increments each cycle (a_req|b_req) is pending with no A/B grant, and saturates at STARVE_LIMIT. It clears to 0 on any A/B grant or when no A/B request is pending. starve = (counter == STARVE_LIMIT).
- Reset, asynchronous assert, mid-operation allowed: bram_addr=0, bram_en=0, rd_data=0, all valids=0, starve=0, counter=0, lock owner cleared, RR pointer=A. In-flight reads are discarded and must never produce a valid after reset. Grants are 0 while rst_n=0.
- Simultaneous events: a d_req and an owner lock release in the same cycle is a D grant, and the lock release takes effect at the owner's next grant. If a_req and b_req both rise in the same cycle as reset deassertion, A is granted first.

Test Plan:
- Single reads: a_req with a_addr=0x0123 alone, bram_dout model returns addr+0x10000 -> a_gnt same cycle, bram_addr=0x0123 next cycle, a_valid with rd_data=0x10123 exactly 3 cycles after acceptance. Repeat for B and D.
- Round-robin: a_req and b_req held high for 6 cycles, no locks -> grants A,B,A,B,A,B with valids following in the same order, 3 cycles delayed.
- Lock burst: A requests 4 corners with a_lock=1 on the first 3 and 0 on the 4th while b_req is held -> A gets 4 consecutive grants, then B is granted.
- Display preemption: d_req pulses for 2 cycles during an A lock burst -> a_gnt=0 for those cycles, D valids appear in order, and A resumes with lock intact.
- Starvation: STARVE_LIMIT=8, d_req held continuously with a_req=1 -> starve rises on the 9th denied cycle. It clears the cycle after d_req drops and A is granted.
- Reset mid-flight: assert rst_n=0 one cycle after an A acceptance -> no a_valid ever appears, all outputs read 0, and the first post-reset contention grants A.

Source files
------------

// File: rtl/ii_read_arbiter.sv
// Read-port arbiter for integral_image_buffer: display (D) has absolute priority,
// evaluator (A) and variance unit (B) share the rest round-robin with optional burst locks.
module ii_read_arbiter #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 20,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_lock,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              d_valid,
    output logic              a_valid,
    output logic              b_valid,
    output logic              starve
);

    localparam int unsigned    TAG_LEN = RD_LAT + 1;
    localparam int unsigned    CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_D, TAG_A, TAG_B} tag_t;

    owner_t            owner_q, owner_d;
    logic              rr_b_q;
    logic              sel_a, sel_b;
    tag_t              sel_tag;
    logic [ADDR_W-1:0] sel_addr;
    tag_t              tag_q [TAG_LEN];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Lock-owner state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) owner_q <= OWN_NONE;
        else        owner_q <= owner_d;
    end

    // Selection (D > lock owner > round-robin) and lock-owner next state
    always_comb begin
        owner_d  = owner_q;
        sel_a    = 1'b0;
        sel_b    = 1'b0;
        sel_tag  = TAG_NONE;
        sel_addr = d_addr;
        if (d_req) begin
            sel_tag = TAG_D;
        end else if ((owner_q == OWN_A) && a_req) begin
            sel_a = 1'b1;
        end else if ((owner_q == OWN_B) && b_req) begin
            sel_b = 1'b1;
        end else if (a_req && b_req) begin
            if (rr_b_q) sel_b = 1'b1;
            else        sel_a = 1'b1;
        end else if (a_req) begin
            sel_a = 1'b1;
        end else if (b_req) begin
            sel_b = 1'b1;
        end

        // A D grant leaves ownership untouched unless the owner has withdrawn
        if (sel_a) begin
            sel_tag  = TAG_A;
            sel_addr = a_addr;
            owner_d  = a_lock ? OWN_A : OWN_NONE;
        end else if (sel_b) begin
            sel_tag  = TAG_B;
            sel_addr = b_addr;
            owner_d  = b_lock ? OWN_B : OWN_NONE;
        end else if (((owner_q == OWN_A) && !a_req) || ((owner_q == OWN_B) && !b_req)) begin
            owner_d = OWN_NONE;
        end
    end

    assign a_gnt = sel_a & rst_n;
    assign b_gnt = sel_b & rst_n;

    // Starvation counter: runs while A/B wait, saturates at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (!(a_req || b_req) || sel_a || sel_b) cnt_d = '0;
        else if (cnt_q != LIMIT_C)               cnt_d = cnt_q + CNT_W'(1);
    end

    // Round-robin pointer, address register and tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_b_q    <= 1'b0;
            bram_addr <= '0;
            bram_en   <= 1'b0;
            cnt_q     <= '0;
            starve    <= 1'b0;
            for (int i = 0; i < int'(TAG_LEN); i++) tag_q[i] <= TAG_NONE;
        end else begin
            if (sel_a)      rr_b_q <= 1'b1;
            else if (sel_b) rr_b_q <= 1'b0;
            if (sel_tag != TAG_NONE) bram_addr <= sel_addr;
            bram_en  <= (sel_tag != TAG_NONE);
            cnt_q    <= cnt_d;
            starve   <= (cnt_d == LIMIT_C);
            tag_q[0] <= sel_tag;
            for (int i = 1; i < int'(TAG_LEN); i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Return stage: capture BRAM data and strobe the originating requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            d_valid <= 1'b0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (tag_q[RD_LAT] != TAG_NONE) rd_data <= bram_dout;
            d_valid <= (tag_q[RD_LAT] == TAG_D);
            a_valid <= (tag_q[RD_LAT] == TAG_A);
            b_valid <= (tag_q[RD_LAT] == TAG_B);
        end
    end

endmodule

// File: tb/tb_ii_read_arbiter.sv
// Directed self-checking bench for ii_read_arbiter with a 1-cycle BRAM model
// returning addr + 0x10000.
module tb_ii_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_req, a_req, b_req, a_lock, b_lock;
    logic [14:0] d_addr, a_addr, b_addr;
    logic        a_gnt, b_gnt;
    logic [14:0] bram_addr;
    logic        bram_en;
    logic [19:0] bram_dout = '0;
    logic [19:0] rd_data;
    logic        d_valid, a_valid, b_valid, starve;

    int n_errors = 0;
    int n_checks = 0;

    logic [1:0]  pre_gnt [5] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
    logic [2:0]  pre_vld [5] = '{3'b010, 3'b100, 3'b100, 3'b010, 3'b001};
    logic [19:0] pre_dat [5] = '{20'h10600, 20'h10050, 20'h10051, 20'h10601, 20'h10700};

    ii_read_arbiter #(
        .ADDR_W(15), .DATA_W(20), .RD_LAT(1), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .d_addr(d_addr),
        .a_req(a_req), .a_addr(a_addr), .a_lock(a_lock), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_lock(b_lock), .b_gnt(b_gnt),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
        .rd_data(rd_data), .d_valid(d_valid), .a_valid(a_valid), .b_valid(b_valid),
        .starve(starve)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bram_en) bram_dout <= 20'(bram_addr) + 20'h10000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] vld();
        return {d_valid, a_valid, b_valid};
    endfunction

    task automatic single_read(input int src, input logic [14:0] addr, input string name);
        d_req = (src == 0); a_req = (src == 1); b_req = (src == 2);
        d_addr = addr; a_addr = addr; b_addr = addr;
        #1;
        if (src == 1) check({name, "_gnt"}, 32'(a_gnt), 32'd1);
        if (src == 2) check({name, "_gnt"}, 32'(b_gnt), 32'd1);
        tick();
        d_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
        check({name, "_addr"}, 32'(bram_addr), 32'(addr));
        check({name, "_en"},   32'(bram_en),   32'd1);
        tick();
        check({name, "_early"}, 32'(vld()), 32'd0);
        tick();
        check({name, "_vld"},  32'(vld()), 32'(3'b100 >> src));
        check({name, "_data"}, 32'(rd_data), 32'(20'(addr) + 20'h10000));
        tick();
        check({name, "_late"}, 32'(vld()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d_req = 0; a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
        d_addr = '0; a_addr = '0; b_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",  32'(bram_addr), 32'd0);
        check("rst_en",    32'(bram_en),   32'd0);
        check("rst_data",  32'(rd_data),   32'd0);
        check("rst_vld",   32'(vld()),     32'd0);
        check("rst_starve", 32'(starve),   32'd0);
        a_req = 1; b_req = 1;
        #1;
        check("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        a_req = 0; b_req = 0;
        rst_n = 1'b1;
        tick();

        single_read(1, 15'h0123, "single_a");
        single_read(2, 15'h0456, "single_b");
        single_read(0, 15'h0789, "single_d");

        // Round-robin, both held for 6 cycles
        for (int c = 0; c < 9; c++) begin
            a_req = (c < 6); b_req = (c < 6);
            a_addr = 15'h0200; b_addr = 15'h0300;
            #1;
            if (c < 6) check("rr_gnt", 32'({a_gnt, b_gnt}), (c % 2 == 0) ? 32'd2 : 32'd1);
            if (c >= 3) begin
                check("rr_vld",  32'(vld()),  ((c - 3) % 2 == 0) ? 32'd2 : 32'd1);
                check("rr_data", 32'(rd_data), ((c - 3) % 2 == 0) ? 32'h10200 : 32'h10300);
            end
            tick();
        end

        // Locked 4-read burst from A while B waits
        for (int c = 0; c < 8; c++) begin
            a_req = (c < 4); a_lock = (c < 3); a_addr = 15'(32'h400 + c);
            b_req = (c < 5); b_addr = 15'h0500;
            #1;
            if (c < 4)  check("lock_gnt_a", 32'({a_gnt, b_gnt}), 32'd2);
            if (c == 4) check("lock_gnt_b", 32'({a_gnt, b_gnt}), 32'd1);
            if (c >= 3) begin
                check("lock_vld",  32'(vld()), (c < 7) ? 32'd2 : 32'd1);
                check("lock_data", 32'(rd_data), (c < 7) ? 32'(32'h10400 + c - 3) : 32'h10500);
            end
            tick();
        end
        a_lock = 0;

        // Display preempts an A lock burst; lock survives
        for (int c = 0; c < 9; c++) begin
            d_req = (c == 1) || (c == 2); d_addr = (c == 2) ? 15'h0051 : 15'h0050;
            a_req = (c < 4); a_lock = (c < 3); a_addr = (c == 0) ? 15'h0600 : 15'h0601;
            b_req = (c < 5); b_addr = 15'h0700;
            #1;
            if (c < 5) check("pre_gnt", 32'({a_gnt, b_gnt}), 32'(pre_gnt[c]));
            if (c >= 3 && c < 8) begin
                check("pre_vld",  32'(vld()),  32'(pre_vld[c-3]));
                check("pre_data", 32'(rd_data), 32'(pre_dat[c-3]));
            end
            tick();
        end
        a_lock = 0;

        // Starvation with limit 8 while D holds the port
        for (int c = 0; c < 12; c++) begin
            d_req = (c < 10); d_addr = 15'h0010;
            a_req = (c <= 10); a_addr = 15'h0020;
            #1;
            if (c == 5)  check("starve_gnt0", 32'(a_gnt), 32'd0);
            if (c == 7)  check("starve_8th",  32'(starve), 32'd0);
            if (c == 8)  check("starve_9th",  32'(starve), 32'd1);
            if (c == 9)  check("starve_sat",  32'(starve), 32'd1);
            if (c == 10) begin
                check("starve_gnt", 32'(a_gnt), 32'd1);
                check("starve_hold", 32'(starve), 32'd1);
            end
            if (c == 11) check("starve_clr", 32'(starve), 32'd0);
            tick();
        end
        d_req = 0; a_req = 0;
        repeat (4) tick();

        // Reset one cycle after an A acceptance
        a_req = 1; a_addr = 15'h07FF;
        #1;
        check("mid_gnt", 32'(a_gnt), 32'd1);
        tick();
        a_req = 1; b_req = 1; a_addr = 15'h00AA; b_addr = 15'h00BB;
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", 32'(bram_addr), 32'd0);
        check("mid_rst_en",   32'(bram_en),   32'd0);
        check("mid_rst_data", 32'(rd_data),   32'd0);
        check("mid_rst_vld",  32'(vld()),     32'd0);
        check("mid_rst_stv",  32'(starve),    32'd0);
        check("mid_rst_gnt",  32'({a_gnt, b_gnt}), 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("mid_rst_novld", 32'(vld()), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_gnt_a", 32'({a_gnt, b_gnt}), 32'd2);
        tick();
        a_req = 0;
        #1;
        check("post_rst_gnt_b", 32'({a_gnt, b_gnt}), 32'd1);
        check("post_rst_novld", 32'(vld()), 32'd0);
        tick();
        b_req = 0;
        check("post_rst_novld2", 32'(vld()), 32'd0);
        tick();
        check("post_rst_vld_a",  32'(vld()),   32'd2);
        check("post_rst_data_a", 32'(rd_data), 32'h100AA);
        tick();
        check("post_rst_vld_b",  32'(vld()),   32'd1);
        check("post_rst_data_b", 32'(rd_data), 32'h100BB);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
